// File: rtl/filter_sample_fifo.sv
// filter_sample_fifo: capture FIFO for filtered samples, drained by firmware
// over a Wishbone slave port. Provides status, sticky overflow/underflow flags,
// a saturating drop counter and a level-threshold interrupt.
// Build option: define FIFO_DROP_OLDEST_EN to make a push into a full FIFO
// overwrite the oldest entry instead of discarding the new sample.
module filter_sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq_o
);

  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_OVF    = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              ovf_flag, udf_flag;
  logic [31:0]       ovf_cnt;

  logic              capture_en, irq_en;
  logic [7:0]        irq_level;

  logic        req, rd_req, wr_req;
  logic [1:0]  reg_sel;
  logic        ctrl_wr, clear;
  logic        empty, full;
  logic        pop_req, do_pop, udf_evt;
  logic        push_req, wr_adv, rd_adv, ovf_evt;
  logic [31:0] count_ext, head_ext, rd_mux;

  logic unused_ok;
  assign unused_ok = ^{wbs_dat_i[30:10], wbs_adr_i[1:0]};

  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign rd_req  = req & ~wbs_we_i;
  assign wr_req  = req & wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];
  assign ctrl_wr = wr_req & (reg_sel == REG_CTRL);
  assign clear   = ctrl_wr & wbs_dat_i[31];

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  assign pop_req = rd_req & (reg_sel == REG_DATA);
  assign do_pop  = pop_req & ~empty;
  assign udf_evt = pop_req & empty;

  assign push_req = in_valid & capture_en;

  // A pop in the same cycle frees a slot, so a full FIFO only rejects
  // (or overwrites) when no pop accompanies the push.
`ifdef FIFO_DROP_OLDEST_EN
  assign wr_adv  = push_req;
  assign ovf_evt = push_req & full & ~do_pop;
  assign rd_adv  = do_pop | ovf_evt;
`else
  assign wr_adv  = push_req & (~full | do_pop);
  assign ovf_evt = push_req & full & ~do_pop;
  assign rd_adv  = do_pop;
`endif

  assign count_ext = 32'(count);
  assign head_ext  = 32'(mem[rd_ptr]);

  // Register read mux; an empty DATA read returns zero
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:   rd_mux = empty ? '0 : head_ext;
      REG_STATUS: rd_mux = {20'd0, udf_flag, ovf_flag, full, empty, count_ext[7:0]};
      REG_CTRL:   rd_mux = {22'd0, irq_level, irq_en, capture_en};
      REG_OVF:    rd_mux = ovf_cnt;
      default:    rd_mux = '0;
    endcase
  end

  // Sample storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_adv && !clear) mem[wr_ptr] <= in_data;
  end

  // Wishbone ack and read data register; data held between acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= rd_mux;
    end
  end

  // Control register; the clear bit is a strobe and is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_en <= 1'b0;
      irq_en     <= 1'b0;
      irq_level  <= '0;
    end else if (ctrl_wr) begin
      capture_en <= wbs_dat_i[0];
      irq_en     <= wbs_dat_i[1];
      irq_level  <= wbs_dat_i[9:2];
    end
  end

  // Pointers and occupancy; clear takes priority over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_adv) wr_ptr <= wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_adv) - CW'(rd_adv);
    end
  end

  // Sticky flags and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if (clear) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      if (ovf_evt) ovf_flag <= 1'b1;
      if (udf_evt) udf_flag <= 1'b1;
      if (ovf_evt && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 32'd1;
    end
  end

  // Level interrupt, registered from the current occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= irq_en & (count_ext >= 32'(irq_level)) & (irq_level != 8'd0);
  end

endmodule

// File: tb/tb_filter_sample_fifo.sv
// Directed self-checking bench for filter_sample_fifo.
module tb_filter_sample_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  filter_sample_fifo #(.DATA_W(24), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin seen = 1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = a;
    wait_ack("rd_ack");
    d = wbs_dat_o;
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = a; wbs_dat_i = d;
    wait_ack("wr_ack");
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic push(input logic [23:0] d);
    @(negedge clk);
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    logic [31:0] r;
    int base;
    rst_n = 0; in_data = '0; in_valid = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    @(negedge clk); rst_n = 1;

    // Reset state and underflow
    wb_read(4'h4, r); chk("status_rst", r, 32'h100);
    wb_read(4'h0, r); chk("data_empty", r, 32'h0);
    wb_read(4'h4, r); chk("status_udf", r, 32'h900);

    // Basic push/pop with zero-extension
    wb_write(4'h8, 32'h1);
    push(24'h000001); push(24'h800002); push(24'hFFFFFF);
    wb_read(4'h0, r); chk("data0", r, 32'h00000001);
    wb_read(4'h0, r); chk("data1", r, 32'h00800002);
    wb_read(4'h0, r); chk("data2", r, 32'h00FFFFFF);
    wb_read(4'h4, r); chk("status_drained", r, 32'h900);
    wb_write(4'h4, 32'hFFFFFFFF);
    wb_read(4'h4, r); chk("status_ro", r, 32'h900);

    // Overflow: 20 pushes into 16 entries
    for (int i = 1; i <= 20; i++) push(24'(i));
    wb_read(4'h4, r); chk("status_full", r, 32'hE10);
    wb_read(4'hC, r); chk("ovf_cnt4", r, 32'd4);

`ifdef FIFO_DROP_OLDEST_EN
    base = 5;
`else
    base = 1;
`endif
    // Pop coinciding with a push while full
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 4'h0;
    in_valid = 1; in_data = 24'd21;
    @(posedge clk); #1;
    chk("simul_ack", 32'(wbs_ack_o), 32'd1);
    chk("simul_data", wbs_dat_o, 32'(base));
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0; in_valid = 0;
    wb_read(4'h4, r); chk("status_simul", r, 32'hE10);
    wb_read(4'hC, r); chk("ovf_simul", r, 32'd4);
    for (int i = 1; i <= 15; i++) begin
      wb_read(4'h0, r); chk("drain", r, 32'(base + i));
    end
    wb_read(4'h0, r); chk("drain_last", r, 32'd21);
    wb_read(4'h4, r); chk("status_empty_flags", r, 32'hD00);

    // Interrupt threshold at level 4
    wb_write(4'h8, 32'h13);
    push(24'hA1); push(24'hA2); push(24'hA3);
    @(posedge clk); #1;
    chk("irq_below", 32'(irq_o), 32'd0);
    push(24'hA4);
    chk("irq_lag", 32'(irq_o), 32'd0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq_o), 32'd1);
    wb_read(4'h0, r); chk("irq_pop_data", r, 32'hA1);
    chk("irq_still", 32'(irq_o), 32'd1);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq_o), 32'd0);

    // Clear racing a push
    push(24'hB1); push(24'hB2);
    wb_read(4'h4, r); chk("status_five", r, 32'hC05);
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 4'h8; wbs_dat_i = 32'h80000013;
    in_valid = 1; in_data = 24'hC1;
    @(posedge clk); #1;
    chk("clr_ack", 32'(wbs_ack_o), 32'd1);
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; in_valid = 0;
    wb_read(4'h4, r); chk("status_cleared", r, 32'h100);
    wb_read(4'hC, r); chk("ovf_cleared", r, 32'd0);
    wb_read(4'h8, r); chk("ctrl_readback", r, 32'h13);

    // Reset in the middle of an ack
    push(24'hD1); push(24'hD2); push(24'hD3); push(24'hD4);
    @(posedge clk); @(posedge clk); #1;
    chk("irq_pre_rst", 32'(irq_o), 32'd1);
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 4'h4;
    @(posedge clk); #1;
    chk("mid_ack", 32'(wbs_ack_o), 32'd1);
    chk("mid_dat", wbs_dat_o, 32'h4);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_mid_dat", wbs_dat_o, 32'd0);
    chk("rst_mid_irq", 32'(irq_o), 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_sample_fifo.md
Name: filter_sample_fifo

Overview:
- Downstream capture stage for the filter datapath's result bus: data_out (24 bit) qualified by the data_ack strobe.
- Buffers each filtered sample in a FIFO so that management-SoC firmware can drain results over Wishbone without losing samples between polls.
- Provides status and overflow accounting, plus a level-threshold interrupt.
- Sits beside the filter core inside the user project wrapper, on the same clock.

Parameters:
- DATA_W, 24, sample width from the filter; must be ≤ 32.
- DEPTH, 16, FIFO entries; must be a power of 2 and ≥ 4.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  single clock for the whole block; the filter core uses the same clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  filtered sample (filter data_out).
- in_valid  in  1  one-cycle sample strobe (filter data_ack).
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_adr_i  in  4  byte offset; bits [3:2] select the register.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  level interrupt.

Behaviour:
- **Reset.** While rst_n=0, asynchronously clear:
  - wbs_ack_o, wbs_dat_o and irq_o to 0;
  - both pointers, count, the sticky flags and the overflow counter;
  - CTRL to 0 (capture disabled).
  - FIFO storage is not reset.
- **Register map** (offset = wbs_adr_i[3:2]):
  - 0 DATA (RO). Reading pops the FIFO. Returns the head sample zero-extended to 32 bits. If the FIFO is empty it returns 0, does not pop, and sets the UNDERFLOW sticky flag.
  - 1 STATUS (RO).
    - [7:0] count.
    - [8] empty.
    - [9] full.
    - [10] OVERFLOW sticky.
    - [11] UNDERFLOW sticky.
    - Other bits read 0.
  - 2 CTRL (RW).
    - [0] capture_en.
    - [1] irq_en.
    - [9:2] irq_level.
    - [31] clear: self-clearing and reads as 0. Writing 1 empties the FIFO, zeroes both sticky flags and the overflow counter, and keeps the other fields as written.
  - 3 OVF_CNT (RO). Count of dropped samples, 32 bits, saturating at 0xFFFFFFFF.
- **Wishbone handshake.**
  - A request is wbs_cyc_i & wbs_stb_i & ~wbs_ack_o.
  - Ack is registered: wbs_ack_o=1 for exactly one cycle, in the cycle after the request is sampled. wbs_dat_o is valid in that same cycle.
  - Back-to-back requests are therefore acked at most every other cycle.
  - Writes to RO registers are acked and ignored.
  - wbs_dat_o holds its last value when not acking.
  - A DATA pop takes effect on the request cycle. This guarantees exactly one pop per transaction.
- **Push.** Occurs on in_valid=1 & capture_en=1.
  - Not full: the sample is written at wr_ptr; wr_ptr and count advance on the next edge.
  - Full: the sample is dropped, OVERFLOW is set and OVF_CNT is incremented (default build).
  - in_valid is ignored while capture_en=0.
- **Simultaneous push and pop.**
  - FIFO not full: both happen and count is unchanged.
  - FIFO full: the pop frees the slot, the push is accepted, count stays at DEPTH, and there is no overflow.
  - FIFO empty: the pop underflows (returns 0) and the push is accepted, giving count=1.
- **Clear vs push.** A clear in the same cycle as a push wins: the FIFO ends empty.
- **Count width.** Count is AW+1 bits internally and is reported zero-extended into STATUS[7:0].
- **Interrupt.** irq_o is registered: irq_o = irq_en & (count ≥ irq_level) & (irq_level ≠ 0). It updates one cycle after count changes.
- **Wrap-around.** Pointers are AW bits and wrap modulo DEPTH; full/empty is derived from count.
- **Reset mid-transaction.** If reset asserts mid-transaction, the ack is lost; the master must retry.

Optional Feature:
- Macro: FIFO_DROP_OLDEST_EN.
- When defined, a push into a full FIFO overwrites the oldest entry:
  - rd_ptr and wr_ptr both advance and count stays at DEPTH;
  - OVERFLOW is still set and OVF_CNT still increments.
- When not defined, the new sample is discarded, as described in Behaviour.

Test Plan:
- Reset then read STATUS → 0x00000100 (empty=1); read DATA → 0 and STATUS → 0x00000900 (UNDERFLOW set).
- CTRL=0x1. Push 0x000001, 0x800002, 0xFFFFFF. Read DATA three times → 0x00000001, 0x00800002, 0x00FFFFFF; STATUS → empty.
- DEPTH=16, capture on. Push 20 samples 1..20.
  - Default: STATUS count=16, full, OVERFLOW; OVF_CNT=4; reads return 1..16.
  - With FIFO_DROP_OLDEST_EN: reads return 5..20.
- Full FIFO with a DATA read request coinciding with in_valid → count stays 16, OVF_CNT unchanged, and the new sample is read last.
- CTRL = irq_en | capture_en | (irq_level=4 << 2) = 0x13. Push 3 samples → irq_o=0. Push a 4th → irq_o=1 one cycle later. Pop one → irq_o=0.
- Fill 5 samples, write CTRL[31]=1 in the same cycle as a push → count=0, OVF_CNT=0, CTRL reads back with bit31=0. Assert rst_n=0 mid-ack → wbs_ack_o drops immediately and all outputs return to 0.
